// File: rtl/dircc_avalon_st_packet_receiver.sv
// ---------------------------------------------------------------------------
// dircc_avalon_st_packet_receiver
//
// Avalon-ST sink that assembles a fixed-size packet from a stream of beats.
// Beat 0 of a packet lands in the most-significant word of packet_data. Short
// packets are zero-padded, and beats past PACKET_BEATS are dropped. After the
// EOP beat the receiver spends one cycle in DONE. In that cycle ready is low,
// receive_done pulses and packet_data/packet_valid present the new packet.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   data                sink beat data (DATA_WIDTH)
//   empty               unused symbols on the EOP beat (EMPTY_WIDTH)
//   startofpacket       first beat of a packet
//   endofpacket         last beat of a packet
//   valid               source beat valid
//   ready               sink ready (registered)
//   packet_data         assembled packet (PACKET_WIDTH)
//   packet_valid        packet_data holds a complete packet
//   receive_nearly_done final beat is being accepted this cycle (combinational)
//   receive_done        one-cycle pulse in the cycle after the final beat
//
// Build option:
//   DIRCC_RX_EMPTY_MASK_EN  when defined, the low empty*BITS_PER_SYMBOL bits
//                           of the final beat are stored as zero; otherwise
//                           empty is ignored and the full beat is stored.
// ---------------------------------------------------------------------------
module dircc_avalon_st_packet_receiver #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 4,
    parameter int PACKET_BEATS     = 8,
    localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
    localparam int EMPTY_WIDTH     = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1,
    localparam int PACKET_WIDTH    = PACKET_BEATS * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [EMPTY_WIDTH-1:0]  empty,
    input  logic                    startofpacket,
    input  logic                    endofpacket,
    input  logic                    valid,
    output logic                    ready,
    output logic [PACKET_WIDTH-1:0] packet_data,
    output logic                    packet_valid,
    output logic                    receive_nearly_done,
    output logic                    receive_done
);

    localparam int COUNT_WIDTH = $clog2(PACKET_BEATS + 1);
    localparam int IDX_WIDTH   = (PACKET_BEATS > 1) ? $clog2(PACKET_BEATS) : 1;
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(PACKET_BEATS);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0]   words      [PACKET_BEATS];
    logic [DATA_WIDTH-1:0]   next_words [PACKET_BEATS];
    logic [PACKET_WIDTH-1:0] next_packet;
    logic [DATA_WIDTH-1:0]   beat_word;
    logic                    accept;

    assign accept = valid && ready;

    // The final beat is an accepted EOP that belongs to a packet: either it
    // opens one itself (SOP+EOP) or a packet is already being assembled.
    assign receive_nearly_done = accept && endofpacket
                                 && (startofpacket || (state == RECV));

    // Word actually stored for the current beat. With masking enabled, the
    // unused trailing symbols of the EOP beat are forced to zero so that
    // packet_data never carries stale bytes beyond the real payload.
`ifdef DIRCC_RX_EMPTY_MASK_EN
    always_comb begin
        beat_word = data;
        if (endofpacket) begin
            for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
                if (s < int'(empty)) begin
                    beat_word[s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] = '0;
                end
            end
        end
    end
`else
    logic unused_empty;
    assign unused_empty = ^empty;

    always_comb begin
        beat_word = data;
    end
`endif

    // Buffer contents after this cycle's beat. An SOP clears every word so a
    // short packet ends up zero-padded. Once the buffer is full, further
    // beats are dropped instead of wrapping onto word 0.
    always_comb begin
        next_words = words;
        if (accept && startofpacket) begin
            for (int i = 0; i < PACKET_BEATS; i++) begin
                next_words[i] = '0;
            end
            next_words[0] = beat_word;
        end else if (accept && (state == RECV) && (count < MAX_COUNT)) begin
            next_words[count[IDX_WIDTH-1:0]] = beat_word;
        end
    end

    // Flatten the buffer with word 0 in the most-significant position.
    // packet_data is loaded from this on the final beat, so it already
    // includes that beat when DONE is entered.
    always_comb begin
        next_packet = '0;
        for (int i = 0; i < PACKET_BEATS; i++) begin
            next_packet[PACKET_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH] = next_words[i];
        end
    end

    // Receive state machine. ready defaults high, so it rises on the first
    // edge after reset and again on leaving DONE. The final beat drops it for
    // exactly one bubble cycle. packet_valid falls one cycle after a new SOP is
    // accepted. It is set again when that packet completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ready        <= 1'b0;
            count        <= '0;
            words        <= '{default: '0};
            packet_data  <= '0;
            packet_valid <= 1'b0;
            receive_done <= 1'b0;
        end else begin
            ready        <= 1'b1;
            receive_done <= 1'b0;
            case (state)
                IDLE, RECV: begin
                    if (accept) begin
                        words <= next_words;
                        if (startofpacket) begin
                            count        <= COUNT_WIDTH'(1);
                            packet_valid <= 1'b0;
                            state        <= RECV;
                        end else if ((state == RECV) && (count < MAX_COUNT)) begin
                            count <= count + 1'b1;
                        end
                        if (receive_nearly_done) begin
                            state        <= DONE;
                            ready        <= 1'b0;
                            receive_done <= 1'b1;
                            packet_data  <= next_packet;
                            packet_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dircc_avalon_st_packet_receiver.sv
// ---------------------------------------------------------------------------
// tb_dircc_avalon_st_packet_receiver
//
// Self-checking bench for dircc_avalon_st_packet_receiver with default
// parameters (8-bit symbols, 4 symbols/beat, 8 beats/packet).
// A table of directed vectors carries constant expectations. Hand-written
// sequences cover the reset cases, and a random run follows. Every cycle is
// also compared against a packet-level reference model built on a beat queue.
// ---------------------------------------------------------------------------
module tb_dircc_avalon_st_packet_receiver;

    localparam int DW = 32;
    localparam int PB = 8;
    localparam int PW = DW * PB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] data;
    logic [1:0]    empty;
    logic          startofpacket;
    logic          endofpacket;
    logic          valid;
    logic          ready;
    logic [PW-1:0] packet_data;
    logic          packet_valid;
    logic          receive_nearly_done;
    logic          receive_done;

    int total = 0;
    int bad   = 0;

    dircc_avalon_st_packet_receiver dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .data                (data),
        .empty               (empty),
        .startofpacket       (startofpacket),
        .endofpacket         (endofpacket),
        .valid               (valid),
        .ready               (ready),
        .packet_data         (packet_data),
        .packet_valid        (packet_valid),
        .receive_nearly_done (receive_nearly_done),
        .receive_done        (receive_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        bit            sop;
        bit            eop;
        logic [DW-1:0] d;
        logic [1:0]    e;
        bit            chk_hs;
        bit            ex_ready;
        bit            ex_near;
        bit            ex_done;
        bit            chk_pkt;
        logic [PW-1:0] ex_pkt;
    } vec_t;

    vec_t tbl[$];

    // Reference model: the beats of the packet being assembled, whether a
    // packet is open, and the visible outputs expected for the current cycle.
    logic [DW-1:0] m_beats[$];
    bit            m_in_packet;
    bit            m_bubble;
    bit            m_done;
    bit            m_pv;
    logic [PW-1:0] m_pkt;
    logic [1:0]    m_last_empty;

    function automatic vec_t mkVec(bit v, bit sop, bit eop, logic [DW-1:0] d,
                                   logic [1:0] e, bit chk_hs, bit rdy, bit near,
                                   bit done, bit chk_pkt, logic [PW-1:0] pkt);
        vec_t r;
        r.v = v; r.sop = sop; r.eop = eop; r.d = d; r.e = e;
        r.chk_hs = chk_hs; r.ex_ready = rdy; r.ex_near = near; r.ex_done = done;
        r.chk_pkt = chk_pkt; r.ex_pkt = pkt;
        return r;
    endfunction

    function automatic logic [PW-1:0] modelPacket();
        logic [PW-1:0] p;
        logic [DW-1:0] w;
        int            n;
        int            sh;
        p = '0;
        n = m_beats.size();
        for (int i = 0; i < n && i < PB; i++) begin
            w = m_beats[i];
`ifdef DIRCC_RX_EMPTY_MASK_EN
            if (i == n - 1) begin
                sh = 8 * int'(m_last_empty);
                w  = (w >> sh) << sh;
            end
`else
            sh = 0;
`endif
            p[PW-1-i*DW -: DW] = w;
        end
        return p;
    endfunction

    task automatic modelReset();
        m_beats.delete();
        m_in_packet = 1'b0;
        m_bubble    = 1'b0;
        m_done      = 1'b0;
        m_pv        = 1'b0;
        m_pkt       = '0;
        m_last_empty = 2'd0;
    endtask

    task automatic checkOutput(input string name, input logic [PW-1:0] actual,
                               input logic [PW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle, compare against the model and any table expectations,
    // then advance the model across the rising edge.
    task automatic applyStimulus(input vec_t vc, input string tag);
        bit exp_ready;
        bit acc;
        bit near;
        @(negedge clk);
        valid         = vc.v;
        startofpacket = vc.sop;
        endofpacket   = vc.eop;
        data          = vc.d;
        empty         = vc.e;
        #1;
        exp_ready = !m_bubble;
        acc       = vc.v && exp_ready;
        near      = acc && vc.eop && (vc.sop || m_in_packet);
        checkOutput({tag, " model ready"}, PW'(ready), PW'(exp_ready));
        checkOutput({tag, " model nearly_done"}, PW'(receive_nearly_done), PW'(near));
        checkOutput({tag, " model receive_done"}, PW'(receive_done), PW'(m_done));
        checkOutput({tag, " model packet_valid"}, PW'(packet_valid), PW'(m_pv));
        checkOutput({tag, " model packet_data"}, packet_data, m_pkt);
        if (vc.chk_hs) begin
            checkOutput({tag, " tbl ready"}, PW'(ready), PW'(vc.ex_ready));
            checkOutput({tag, " tbl nearly_done"}, PW'(receive_nearly_done), PW'(vc.ex_near));
            checkOutput({tag, " tbl receive_done"}, PW'(receive_done), PW'(vc.ex_done));
        end
        if (vc.chk_pkt) begin
            checkOutput({tag, " tbl packet_valid"}, PW'(packet_valid), PW'(1'b1));
            checkOutput({tag, " tbl packet_data"}, packet_data, vc.ex_pkt);
        end
        @(posedge clk);
        m_done = near;
        if (acc && vc.sop) begin
            m_beats.delete();
            m_beats.push_back(vc.d);
            m_in_packet = 1'b1;
            m_pv        = 1'b0;
        end else if (acc && m_in_packet) begin
            m_beats.push_back(vc.d);
        end
        if (near) begin
            m_last_empty = vc.e;
            m_pkt        = modelPacket();
            m_pv         = 1'b1;
            m_in_packet  = 1'b0;
        end
        m_bubble = near;
    endtask

    // Assert reset asynchronously, check the cleared outputs, release on a
    // falling edge and leave the bench just after the first rising edge.
    task automatic doReset(input string tag);
        valid   = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput({tag, " rst ready"}, PW'(ready), PW'(1'b0));
        checkOutput({tag, " rst packet_valid"}, PW'(packet_valid), PW'(1'b0));
        checkOutput({tag, " rst receive_done"}, PW'(receive_done), PW'(1'b0));
        checkOutput({tag, " rst packet_data"}, packet_data, PW'(0));
        modelReset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput({tag, " release ready"}, PW'(ready), PW'(1'b0));
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [PW-1:0] p1, p2, p3, p4, p5;
        vec_t          vc;

        p1 = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        p2 = {32'h0000000A, 32'h0000000B, 32'h0000000C, 160'h0};
        p3 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
`ifdef DIRCC_RX_EMPTY_MASK_EN
        p4 = {32'hAABBCC00, 224'h0};
`else
        p4 = {32'hAABBCCDD, 224'h0};
`endif
        p5 = {32'h3, 32'h4, 192'h0};

        // Full 8-beat packet with valid held high through the bubble.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mkVec(1, i == 0, i == 7, 32'h11111111 * (i + 1), 2'd0,
                                1, 1, i == 7, 0, 0, '0));
        tbl.push_back(mkVec(1, 0, 0, 32'h99999999, 2'd0, 1, 0, 0, 1, 1, p1));
        // Stray beat in IDLE without SOP is dropped, packet held.
        tbl.push_back(mkVec(1, 0, 1, 32'hDEADBEEF, 2'd0, 1, 1, 0, 0, 1, p1));
        tbl.push_back(mkVec(0, 0, 0, 32'h0, 2'd0, 1, 1, 0, 0, 1, p1));
        // Short 3-beat packet.
        tbl.push_back(mkVec(1, 1, 0, 32'hA, 2'd0, 1, 1, 0, 0, 1, p1));
        tbl.push_back(mkVec(1, 0, 0, 32'hB, 2'd0, 1, 1, 0, 0, 0, '0));
        tbl.push_back(mkVec(1, 0, 1, 32'hC, 2'd0, 1, 1, 1, 0, 0, '0));
        tbl.push_back(mkVec(0, 0, 0, 32'h0, 2'd0, 1, 0, 0, 1, 1, p2));
        // Over-long 10-beat packet.
        for (int i = 0; i < 10; i++)
            tbl.push_back(mkVec(1, i == 0, i == 9, 32'(i + 1), 2'd0,
                                1, 1, i == 9, 0, 0, '0));
        tbl.push_back(mkVec(0, 0, 0, 32'h0, 2'd0, 1, 0, 0, 1, 1, p3));
        // Single SOP+EOP beat with one empty symbol.
        tbl.push_back(mkVec(1, 1, 1, 32'hAABBCCDD, 2'd1, 1, 1, 1, 0, 0, '0));
        tbl.push_back(mkVec(0, 0, 0, 32'h0, 2'd0, 1, 0, 0, 1, 1, p4));
        // SOP in the middle of a packet restarts assembly.
        tbl.push_back(mkVec(1, 1, 0, 32'h1, 2'd0, 1, 1, 0, 0, 0, '0));
        tbl.push_back(mkVec(1, 0, 0, 32'h2, 2'd0, 1, 1, 0, 0, 0, '0));
        tbl.push_back(mkVec(1, 1, 0, 32'h3, 2'd0, 1, 1, 0, 0, 0, '0));
        tbl.push_back(mkVec(1, 0, 1, 32'h4, 2'd0, 1, 1, 1, 0, 0, '0));
        tbl.push_back(mkVec(0, 0, 0, 32'h0, 2'd0, 1, 0, 0, 1, 1, p5));

        valid = 1'b0; startofpacket = 1'b0; endofpacket = 1'b0;
        data = '0; empty = '0;
        modelReset();
        doReset("init");

        foreach (tbl[i]) applyStimulus(tbl[i], $sformatf("vec%0d", i));

        // Reset after beat 4 of 8: partial packet is lost, no done pulse.
        for (int i = 0; i < 4; i++)
            applyStimulus(mkVec(1, i == 0, 0, 32'h55550000 + 32'(i), 2'd0,
                                1, 1, 0, 0, 0, '0), $sformatf("mid%0d", i));
        #2;
        doReset("midpkt");
        for (int i = 0; i < 8; i++)
            applyStimulus(mkVec(1, i == 0, i == 7, 32'h11111111 * (i + 1), 2'd0,
                                1, 1, i == 7, 0, 0, '0), $sformatf("after%0d", i));
        applyStimulus(mkVec(0, 0, 0, 32'h0, 2'd0, 1, 0, 0, 1, 1, p1), "after_done");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            vc = mkVec($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                       $urandom_range(0, 9) < 3, $urandom, 2'($urandom_range(0, 3)),
                       0, 0, 0, 0, 0, '0);
            applyStimulus(vc, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
